deserializer_1to2: RTL and testbench
====================================

Name: deserializer_1to2

Overview:
- Receive-side counterpart of the 2:1 serializer.
- Takes one interleaved serial bit stream at full clock rate. Bits alternate lane1, lane2, lane1, lane2, and so on.
- Recovers the lane phase by hunting for a sync word, then outputs registered lane1/lane2 bit pairs with a valid strobe every second cycle.
- Sits after the serial link, in the same clock domain as the serializer's fast clock.

Parameters:
- SYNC_W, 16: sync word width in bits. Must be even, minimum 4.
- SYNC_WORD, 16'hE4C3: alignment pattern, MSB transmitted first. Its last bit is a lane2 bit.

Ports:
- clk  in  1  bit-rate clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- data_i  in  1  serial input bit, sampled every rising edge.
- data1_o  out  1  recovered lane1 bit (registered).
- data2_o  out  1  recovered lane2 bit (registered).
- valid_o  out  1  one-cycle pulse; data1_o/data2_o hold a new pair.
- locked_o  out  1  high while state is LOCKED.
- sync_o  out  1  one-cycle pulse on every sync word detection.
- slip_err_o  out  1  one-cycle pulse when a sync word is found off-phase while LOCKED.

Behaviour:
- Reset (async, any time, including mid-word):
  - All outputs 0.
  - State HUNT, phase 0, shift register cleared, lane1 hold register 0.
- Shift register sr[SYNC_W-1:0]:
  - Updated every cycle as sr <= {sr[SYNC_W-2:0], data_i}.
- match is combinational: ({sr[SYNC_W-2:0], data_i} == SYNC_WORD).
  - It evaluates the window that includes the current input bit.
- HUNT state:
  - valid_o stays 0.
  - On an edge with match=1: go to LOCKED, phase <= 0, sync_o pulses.
  - The next data_i bit is treated as lane1.
- LOCKED state, phase 0: lane1 hold <= data_i; phase <= 1; valid_o 0.
- LOCKED state, phase 1:
  - data1_o <= hold, data2_o <= data_i, valid_o <= 1 for one cycle, phase <= 0.
- Latency: a pair is visible on data1_o/data2_o/valid_o one cycle after its lane2 bit is sampled.
  - That is 2 cycles after its lane1 bit.
- Aligned re-detection: LOCKED, match=1, phase=1.
  - Normal pair output still happens.
  - sync_o pulses; no state change.
- Off-phase detection: LOCKED, match=1, phase=0.
  - Realign: phase <= 0, so the next bit is lane1. The current bit is discarded, not loaded into hold. No valid_o that cycle.
  - slip_err_o and sync_o pulse together. Stay LOCKED.
- data1_o/data2_o hold their values between valid pulses.
- locked_o is registered and equals (state==LOCKED).
- No return from LOCKED to HUNT except via reset. Lock loss is handled by realignment.
- Overlapping sync words are legal. Detection is evaluated every cycle regardless of previous matches.

Optional Feature:
- Macro: DESER_SLIP_EN.
- Defined:
  - Extra input port slip_i (1 bit), placed after data_i.
  - When slip_i=1 while LOCKED, the current data_i bit is dropped: phase, hold and the output registers are unchanged, and no valid_o that cycle.
  - This shifts lane alignment by one bit per slip cycle.
  - slip_i is ignored in HUNT.
  - If slip_i and an off-phase match occur on the same edge, the off-phase realignment wins and slip_err_o pulses.
- Undefined:
  - No slip_i port.
  - Alignment comes only from sync word detection.

Test Plan:
1. Reset with data_i=0 for 40 cycles -> all outputs 0, locked_o=0, no valid_o.
2. Send 16'hE4C3 MSB-first, then lane pairs (1,0),(0,1),(1,1):
   - sync_o pulses on the edge sampling the final '1' bit, and locked_o=1 from the next cycle.
   - valid_o pulses every 2nd cycle with data1_o/data2_o = 1/0, 0/1, 1/1.
   - Each pulse comes one cycle after its lane2 bit.
3. After lock, insert one extra bit, then 16'hE4C3 again ->
   - sync_o and slip_err_o pulse together, with no valid_o that cycle.
   - Following pairs (0,1),(1,0) are recovered correctly.
4. While LOCKED, send an aligned 16'hE4C3 -> sync_o pulses, slip_err_o=0, 8 valid pairs are output with the sync bits (1,1),(1,0),(0,1),(0,0),(1,1),(0,0),(0,0),(1,1).
5. Assert reset mid-pair (after a lane1 bit) -> outputs 0 immediately (asynchronously); after release, no valid_o until a new sync word is received.
6. With DESER_SLIP_EN defined, lock, then assert slip_i for 1 cycle on a lane1 bit -> no valid_o that cycle, and the next pair is formed from the two bits following the dropped bit (pattern 1,0,1,0... then reads as 0/1).

Source files
------------

// File: rtl/deserializer_1to2.sv
// 1:2 serial deserializer: hunts for SYNC_WORD, then splits the bit stream into lane1/lane2 pairs.
// Optional macro DESER_SLIP_EN adds slip_i, which drops one input bit while locked.
module deserializer_1to2 #(
  parameter int                 SYNC_W    = 16,
  parameter logic [SYNC_W-1:0]  SYNC_WORD = 16'hE4C3
) (
  input  logic clk,
  input  logic reset,
  input  logic data_i,
`ifdef DESER_SLIP_EN
  input  logic slip_i,
`endif
  output logic data1_o,
  output logic data2_o,
  output logic valid_o,
  output logic locked_o,
  output logic sync_o,
  output logic slip_err_o
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              phase_q, phase_d;
  logic [SYNC_W-1:0] sr_q, sr_d;
  logic              hold_q, hold_d;
  logic              data1_q, data1_d;
  logic              data2_q, data2_d;
  logic              valid_q, valid_d;
  logic              locked_q, locked_d;
  logic              sync_q, sync_d;
  logic              slip_err_q, slip_err_d;
  logic              match;
  logic              slip_req;

`ifdef DESER_SLIP_EN
  assign slip_req = slip_i;
`else
  assign slip_req = 1'b0;
`endif

  always_comb begin
    sr_d       = {sr_q[SYNC_W-2:0], data_i};
    // The match window includes the bit being sampled on this edge.
    match      = (sr_d == SYNC_WORD);
    state_d    = state_q;
    phase_d    = phase_q;
    hold_d     = hold_q;
    data1_d    = data1_q;
    data2_d    = data2_q;
    valid_d    = 1'b0;
    sync_d     = 1'b0;
    slip_err_d = 1'b0;

    if (state_q == HUNT) begin
      if (match) begin
        state_d = LOCKED;
        phase_d = 1'b0;
        sync_d  = 1'b1;
      end
    end else if (match && !phase_q) begin
      // Off-phase sync: realign so the next bit is lane1; realignment beats a slip.
      phase_d    = 1'b0;
      sync_d     = 1'b1;
      slip_err_d = 1'b1;
    end else begin
      sync_d = match;
      if (!slip_req) begin
        if (!phase_q) begin
          hold_d  = data_i;
          phase_d = 1'b1;
        end else begin
          data1_d = hold_q;
          data2_d = data_i;
          valid_d = 1'b1;
          phase_d = 1'b0;
        end
      end
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= HUNT;
      phase_q    <= 1'b0;
      sr_q       <= '0;
      hold_q     <= 1'b0;
      data1_q    <= 1'b0;
      data2_q    <= 1'b0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      sync_q     <= 1'b0;
      slip_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      sr_q       <= sr_d;
      hold_q     <= hold_d;
      data1_q    <= data1_d;
      data2_q    <= data2_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      sync_q     <= sync_d;
      slip_err_q <= slip_err_d;
    end
  end

  assign data1_o    = data1_q;
  assign data2_o    = data2_q;
  assign valid_o    = valid_q;
  assign locked_o   = locked_q;
  assign sync_o     = sync_q;
  assign slip_err_o = slip_err_q;

endmodule

// File: tb/tb_deserializer_1to2.sv
// Scoreboard bench for deserializer_1to2; define DESER_SLIP_EN to also exercise slip_i.
module tb_deserializer_1to2;

  localparam logic [15:0] SYNC = 16'hE4C3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic data_i = 1'b0;
  logic slip_i = 1'b0;
  logic data1_o, data2_o, valid_o, locked_o, sync_o, slip_err_o;

  deserializer_1to2 dut (
    .clk        (clk),
    .reset      (reset),
    .data_i     (data_i),
`ifdef DESER_SLIP_EN
    .slip_i     (slip_i),
`endif
    .data1_o    (data1_o),
    .data2_o    (data2_o),
    .valid_o    (valid_o),
    .locked_o   (locked_o),
    .sync_o     (sync_o),
    .slip_err_o (slip_err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic v, sy, se, lk, d1, d2;
  } exp_t;

  exp_t        exp_q[$];
  logic [1:0]  pair_log[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          n_sync = 0;
  int          n_slip = 0;

  // reference model state
  logic        m_locked, m_phase, m_hold, m_d1, m_d2;
  logic [15:0] m_win;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 1'b0; m_phase = 1'b0; m_hold = 1'b0;
    m_d1 = 1'b0; m_d2 = 1'b0; m_win = '0;
    exp_q.delete();
  endtask

  // Drive one bit, predict the outputs after the next edge, then compare them.
  task automatic send(input logic b, input logic s);
    exp_t e;
    logic m;
    data_i = b;
    slip_i = s;
    m_win = {m_win[14:0], b};
    m = (m_win == SYNC);
    e = '0;
    if (!m_locked) begin
      if (m) begin
        m_locked = 1'b1; m_phase = 1'b0; e.sy = 1'b1;
      end
    end else if (m && !m_phase) begin
      e.sy = 1'b1; e.se = 1'b1; m_phase = 1'b0;
    end else begin
      e.sy = m;
      if (!s) begin
        if (!m_phase) begin
          m_hold = b; m_phase = 1'b1;
        end else begin
          m_d1 = m_hold; m_d2 = b; e.v = 1'b1; m_phase = 1'b0;
        end
      end
    end
    e.lk = m_locked; e.d1 = m_d1; e.d2 = m_d2;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("valid_o", valid_o, e.v);
    chk("sync_o", sync_o, e.sy);
    chk("slip_err_o", slip_err_o, e.se);
    chk("locked_o", locked_o, e.lk);
    chk("data1_o", data1_o, e.d1);
    chk("data2_o", data2_o, e.d2);
    if (valid_o) pair_log.push_back({data1_o, data2_o});
    if (sync_o) n_sync++;
    if (slip_err_o) n_slip++;
    @(negedge clk);
    slip_i = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send(w[i], 1'b0);
  endtask

  task automatic check_log(input string tag, input logic [1:0] exp[$]);
    chk({tag, "_count"}, pair_log.size(), exp.size());
    for (int i = 0; i < exp.size() && i < pair_log.size(); i++)
      chk(tag, pair_log[i], exp[i]);
    pair_log.delete();
  endtask

  initial begin
    logic [1:0] exp_pairs[$];
    model_reset();

    // 1: long reset with zeros on the line
    repeat (40) @(negedge clk);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_locked", locked_o, 1'b0);
    chk("rst_data", {data1_o, data2_o, sync_o, slip_err_o}, 4'b0);
    reset = 1'b0;
    repeat (4) send(1'b0, 1'b0);

    // 2: acquire lock and recover three pairs
    send_word(SYNC);
    chk("lock_sync_cnt", n_sync, 1);
    send(1'b1, 1'b0); send(1'b0, 1'b0);
    send(1'b0, 1'b0); send(1'b1, 1'b0);
    send(1'b1, 1'b0); send(1'b1, 1'b0);
    exp_pairs = '{2'b10, 2'b01, 2'b11};
    check_log("t2_pair", exp_pairs);

    // 3: one extra bit, then an off-phase sync word
    n_sync = 0; n_slip = 0;
    send(1'b0, 1'b0);
    send_word(SYNC);
    chk("t3_slip_cnt", n_slip, 1);
    chk("t3_sync_cnt", n_sync, 1);
    pair_log.delete();
    send(1'b0, 1'b0); send(1'b1, 1'b0);
    send(1'b1, 1'b0); send(1'b0, 1'b0);
    exp_pairs = '{2'b01, 2'b10};
    check_log("t3_pair", exp_pairs);

    // 4: aligned sync word while locked
    n_sync = 0; n_slip = 0;
    send_word(SYNC);
    chk("t4_sync_cnt", n_sync, 1);
    chk("t4_slip_cnt", n_slip, 0);
    exp_pairs = '{2'b11, 2'b10, 2'b01, 2'b00, 2'b11, 2'b00, 2'b00, 2'b11};
    check_log("t4_pair", exp_pairs);

    // 5: asynchronous reset right after a lane1 bit
    chk("t5_pre_d1", data1_o, 1'b1);
    send(1'b1, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_d1", data1_o, 1'b0);
    chk("t5_async_d2", data2_o, 1'b0);
    chk("t5_async_locked", locked_o, 1'b0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) send(i[0], 1'b0);
    chk("t5_no_valid", pair_log.size(), 0);
    send_word(SYNC);
    send(1'b0, 1'b0); send(1'b1, 1'b0);
    exp_pairs = '{2'b01};
    check_log("t5_pair", exp_pairs);

`ifdef DESER_SLIP_EN
    // 6: slip on a lane1 bit of a 1,0,1,0 stream
    send(1'b1, 1'b1);
    chk("t6_slip_valid", valid_o, 1'b0);
    send(1'b0, 1'b0); send(1'b1, 1'b0);
    send(1'b0, 1'b0); send(1'b1, 1'b0);
    exp_pairs = '{2'b01, 2'b01};
    check_log("t6_pair", exp_pairs);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
